// File: rtl/rapid_pkg.sv
// Shared RAPID core definitions: widths, the NOP encoding, RV32I opcodes and decode classes.
package rapid_pkg;

  localparam int XLEN = 32;

  localparam logic [31:0] NOOP_INSTRUCTION = 32'h0000_0013;

  localparam logic [6:0] OPC_LUI      = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
  localparam logic [6:0] OPC_JAL      = 7'b1101111;
  localparam logic [6:0] OPC_JALR     = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
  localparam logic [6:0] OPC_LOAD     = 7'b0000011;
  localparam logic [6:0] OPC_STORE    = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
  localparam logic [6:0] OPC_OP       = 7'b0110011;
  localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

  typedef enum logic [3:0] {
    CLASS_LUI,
    CLASS_AUIPC,
    CLASS_JAL,
    CLASS_JALR,
    CLASS_BRANCH,
    CLASS_LOAD,
    CLASS_STORE,
    CLASS_OP_IMM,
    CLASS_OP,
    CLASS_SYSTEM,
    CLASS_FENCE,
    CLASS_ILLEGAL
  } op_class_t;

  typedef enum logic [2:0] {
    FMT_R,
    FMT_I,
    FMT_S,
    FMT_B,
    FMT_U,
    FMT_J
  } imm_fmt_t;

endpackage

// File: rtl/rv32i_decoder.sv
// Combinational RV32I decoder: fields, sign-extended immediate, class and legality.
// Zero latency; no flow control. Illegal words report zero rs1/rs2/imm and no rd write.
module rv32i_decoder
  import rapid_pkg::*;
(
  input  logic [31:0] instr,
  output logic [4:0]  rs1,
  output logic [4:0]  rs2,
  output logic [4:0]  rd,
  output logic        rd_we,
  output logic [31:0] imm,
  output op_class_t   op_class,
  output logic [2:0]  funct3,
  output logic        funct7b5,
  output logic        illegal
);

  logic [6:0]  opcode;
  logic [2:0]  f3;
  logic [6:0]  f7;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j, imm_sel;
  op_class_t   cls;
  imm_fmt_t    fmt;
  logic        use_rs1, use_rs2, writes_rd, legal;

  assign opcode = instr[6:0];
  assign f3     = instr[14:12];
  assign f7     = instr[31:25];

  assign imm_i = {{20{instr[31]}}, instr[31:20]};
  assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
  assign imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  assign imm_u = {instr[31:12], 12'b0};
  assign imm_j = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

  always_comb begin
    cls       = CLASS_ILLEGAL;
    fmt       = FMT_R;
    use_rs1   = 1'b0;
    use_rs2   = 1'b0;
    writes_rd = 1'b0;
    legal     = 1'b0;
    case (opcode)
      OPC_LUI: begin
        cls = CLASS_LUI; fmt = FMT_U; writes_rd = 1'b1; legal = 1'b1;
      end
      OPC_AUIPC: begin
        cls = CLASS_AUIPC; fmt = FMT_U; writes_rd = 1'b1; legal = 1'b1;
      end
      OPC_JAL: begin
        cls = CLASS_JAL; fmt = FMT_J; writes_rd = 1'b1; legal = 1'b1;
      end
      OPC_JALR: begin
        cls = CLASS_JALR; fmt = FMT_I; use_rs1 = 1'b1; writes_rd = 1'b1;
        legal = (f3 == 3'b000);
      end
      OPC_BRANCH: begin
        cls = CLASS_BRANCH; fmt = FMT_B; use_rs1 = 1'b1; use_rs2 = 1'b1;
        legal = (f3[2:1] != 2'b01);
      end
      OPC_LOAD: begin
        cls = CLASS_LOAD; fmt = FMT_I; use_rs1 = 1'b1; writes_rd = 1'b1;
        legal = (f3 != 3'b011) && (f3 != 3'b110) && (f3 != 3'b111);
      end
      OPC_STORE: begin
        cls = CLASS_STORE; fmt = FMT_S; use_rs1 = 1'b1; use_rs2 = 1'b1;
        legal = !f3[2] && (f3 != 3'b011);
      end
      OPC_OP_IMM: begin
        cls = CLASS_OP_IMM; fmt = FMT_I; use_rs1 = 1'b1; writes_rd = 1'b1;
        // Only the shift encodings constrain the upper immediate bits.
        if (f3 == 3'b001)      legal = (f7 == 7'h00);
        else if (f3 == 3'b101) legal = (f7 == 7'h00) || (f7 == 7'h20);
        else                   legal = 1'b1;
      end
      OPC_OP: begin
        cls = CLASS_OP; fmt = FMT_R; use_rs1 = 1'b1; use_rs2 = 1'b1; writes_rd = 1'b1;
        legal = (f7 == 7'h00) || ((f7 == 7'h20) && ((f3 == 3'b000) || (f3 == 3'b101)));
      end
      OPC_MISC_MEM: begin
        cls = CLASS_FENCE; fmt = FMT_I; legal = (f3 == 3'b000);
      end
      OPC_SYSTEM: begin
        // CSR forms with funct3[2] set carry a uimm in the rs1 slot.
        cls = CLASS_SYSTEM; fmt = FMT_I;
        use_rs1   = !f3[2] && (f3[1:0] != 2'b00);
        writes_rd = (f3 != 3'b000);
        legal     = (f3 != 3'b100);
      end
      default: ;
    endcase
  end

  always_comb begin
    imm_sel = 32'd0;
    case (fmt)
      FMT_I:   imm_sel = imm_i;
      FMT_S:   imm_sel = imm_s;
      FMT_B:   imm_sel = imm_b;
      FMT_U:   imm_sel = imm_u;
      FMT_J:   imm_sel = imm_j;
      default: imm_sel = 32'd0;
    endcase
  end

  assign illegal  = !legal;
  assign op_class = legal ? cls : CLASS_ILLEGAL;
  assign rs1      = (legal && use_rs1) ? instr[19:15] : 5'd0;
  assign rs2      = (legal && use_rs2) ? instr[24:20] : 5'd0;
  assign rd       = instr[11:7];
  assign rd_we    = legal && writes_rd && (instr[11:7] != 5'd0);
  assign imm      = legal ? imm_sel : 32'd0;
  assign funct3   = f3;
  assign funct7b5 = instr[30];

endmodule

// File: rtl/cpu_decode_unit.sv
// RAPID decode stage: one registered instruction decoded for execute, 1-cycle fetch-to-output latency.
// Holds while execute stalls (fetch sees not-ready); an execute redirect squashes the stage.
module cpu_decode_unit
  import rapid_pkg::*;
#(
  parameter int XLEN      = rapid_pkg::XLEN,
  parameter int CNT_WIDTH = 32
) (
  input  logic                 i_clk,
  input  logic                 i_reset,
  input  logic [XLEN-1:0]      i_if_pc,
  input  logic [31:0]          i_if_instruction,
  output logic                 o_if_ready,
  output logic                 o_if_pc_load,
  output logic [XLEN-1:0]      o_if_ext_pc,
  input  logic                 i_redirect,
  input  logic [XLEN-1:0]      i_redirect_pc,
  input  logic                 i_ex_ready,
  output logic                 o_valid,
  output logic [XLEN-1:0]      o_pc,
  output logic [31:0]          o_instruction,
  output logic [4:0]           o_rs1,
  output logic [4:0]           o_rs2,
  output logic [4:0]           o_rd,
  output logic                 o_rd_we,
  output logic [XLEN-1:0]      o_imm,
  output op_class_t            o_op_class,
  output logic [2:0]           o_funct3,
  output logic                 o_funct7b5,
  output logic                 o_illegal,
  output logic [CNT_WIDTH-1:0] o_decoded_cnt,
  output logic [CNT_WIDTH-1:0] o_bubble_cnt
);

  logic                 valid_q;
  logic [XLEN-1:0]      pc_q;
  logic [31:0]          instr_q;
  logic [CNT_WIDTH-1:0] decoded_cnt_q, bubble_cnt_q;
  logic                 advance, capture, fetch_real;
  logic [31:0]          dec_imm;

  assign advance    = !valid_q || i_ex_ready;
  assign capture    = advance && !i_redirect;
  assign fetch_real = (i_if_instruction != NOOP_INSTRUCTION);

  // Redirect forces ready so fetch drops whatever it holds and loads the new PC.
  assign o_if_ready   = advance || i_redirect;
  assign o_if_pc_load = i_redirect;
  assign o_if_ext_pc  = i_redirect_pc;

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      valid_q <= 1'b0;
      pc_q    <= '0;
      instr_q <= NOOP_INSTRUCTION;
    end else if (i_redirect) begin
      valid_q <= 1'b0;
      pc_q    <= '0;
      instr_q <= NOOP_INSTRUCTION;
    end else if (advance) begin
      valid_q <= fetch_real;
      pc_q    <= i_if_pc;
      instr_q <= i_if_instruction;
    end
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      decoded_cnt_q <= '0;
      bubble_cnt_q  <= '0;
    end else begin
      if (valid_q && i_ex_ready && !i_redirect)
        decoded_cnt_q <= decoded_cnt_q + CNT_WIDTH'(1);
      if (capture && !fetch_real)
        bubble_cnt_q <= bubble_cnt_q + CNT_WIDTH'(1);
    end
  end

  rv32i_decoder u_dec (
    .instr    (instr_q),
    .rs1      (o_rs1),
    .rs2      (o_rs2),
    .rd       (o_rd),
    .rd_we    (o_rd_we),
    .imm      (dec_imm),
    .op_class (o_op_class),
    .funct3   (o_funct3),
    .funct7b5 (o_funct7b5),
    .illegal  (o_illegal)
  );

  assign o_imm         = XLEN'($signed(dec_imm));
  assign o_valid       = valid_q;
  assign o_pc          = pc_q;
  assign o_instruction = instr_q;
  assign o_decoded_cnt = decoded_cnt_q;
  assign o_bubble_cnt  = bubble_cnt_q;

endmodule

// File: tb/tb_cpu_decode_unit.sv
// Directed bench for cpu_decode_unit: fetch stub queue, architectural model and per-cycle compare.
module tb_cpu_decode_unit;
  import rapid_pkg::*;

  logic        i_clk = 1'b0;
  logic        i_reset;
  logic [31:0] i_if_pc, i_if_instruction;
  logic        o_if_ready, o_if_pc_load;
  logic [31:0] o_if_ext_pc;
  logic        i_redirect;
  logic [31:0] i_redirect_pc;
  logic        i_ex_ready;
  logic        o_valid;
  logic [31:0] o_pc, o_instruction;
  logic [4:0]  o_rs1, o_rs2, o_rd;
  logic        o_rd_we;
  logic [31:0] o_imm;
  op_class_t   o_op_class;
  logic [2:0]  o_funct3;
  logic        o_funct7b5, o_illegal;
  logic [31:0] o_decoded_cnt, o_bubble_cnt;

  cpu_decode_unit #(.XLEN(32), .CNT_WIDTH(32)) dut (
    .i_clk(i_clk), .i_reset(i_reset),
    .i_if_pc(i_if_pc), .i_if_instruction(i_if_instruction),
    .o_if_ready(o_if_ready), .o_if_pc_load(o_if_pc_load), .o_if_ext_pc(o_if_ext_pc),
    .i_redirect(i_redirect), .i_redirect_pc(i_redirect_pc), .i_ex_ready(i_ex_ready),
    .o_valid(o_valid), .o_pc(o_pc), .o_instruction(o_instruction),
    .o_rs1(o_rs1), .o_rs2(o_rs2), .o_rd(o_rd), .o_rd_we(o_rd_we), .o_imm(o_imm),
    .o_op_class(o_op_class), .o_funct3(o_funct3), .o_funct7b5(o_funct7b5),
    .o_illegal(o_illegal), .o_decoded_cnt(o_decoded_cnt), .o_bubble_cnt(o_bubble_cnt)
  );

  always #5 i_clk = ~i_clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference decode written directly from the ISA tables with integer immediate arithmetic.
  typedef struct {
    op_class_t   cls;
    logic [4:0]  rs1, rs2;
    logic        rd_we;
    logic [31:0] imm;
    logic        ill;
  } ref_t;

  function automatic ref_t ref_decode(input logic [31:0] w);
    ref_t r;
    int sw, ii, si, bi, ui, ji, imm;
    bit ok, r1, r2, wr;
    int f3, f7;
    sw = $signed(w);
    f3 = int'(w[14:12]);
    f7 = int'(w[31:25]);
    ii = sw >>> 20;
    si = (sw >>> 25) * 32 + int'(w[11:7]);
    bi = (w[31] ? -4096 : 0) + (w[7] ? 2048 : 0) + int'(w[30:25]) * 32 + int'(w[11:8]) * 2;
    ui = int'(w & 32'hFFFF_F000);
    ji = (w[31] ? -1048576 : 0) + int'(w[19:12]) * 4096 + (w[20] ? 2048 : 0) + int'(w[30:21]) * 2;
    ok = 0; r1 = 0; r2 = 0; wr = 0; imm = 0;
    r.cls = CLASS_ILLEGAL;
    case (w[6:0])
      7'h37: begin r.cls = CLASS_LUI;    imm = ui; wr = 1; ok = 1; end
      7'h17: begin r.cls = CLASS_AUIPC;  imm = ui; wr = 1; ok = 1; end
      7'h6F: begin r.cls = CLASS_JAL;    imm = ji; wr = 1; ok = 1; end
      7'h67: begin r.cls = CLASS_JALR;   imm = ii; wr = 1; r1 = 1; ok = (f3 == 0); end
      7'h63: begin r.cls = CLASS_BRANCH; imm = bi; r1 = 1; r2 = 1; ok = !(f3 == 2 || f3 == 3); end
      7'h03: begin r.cls = CLASS_LOAD;   imm = ii; wr = 1; r1 = 1;
                   ok = (f3 == 0 || f3 == 1 || f3 == 2 || f3 == 4 || f3 == 5); end
      7'h23: begin r.cls = CLASS_STORE;  imm = si; r1 = 1; r2 = 1; ok = (f3 <= 2); end
      7'h13: begin r.cls = CLASS_OP_IMM; imm = ii; wr = 1; r1 = 1;
                   ok = (f3 == 1) ? (f7 == 0) : (f3 == 5) ? (f7 == 0 || f7 == 32) : 1'b1; end
      7'h33: begin r.cls = CLASS_OP;     imm = 0; wr = 1; r1 = 1; r2 = 1;
                   ok = (f7 == 0) || (f7 == 32 && (f3 == 0 || f3 == 5)); end
      7'h0F: begin r.cls = CLASS_FENCE;  imm = ii; ok = (f3 == 0); end
      7'h73: begin r.cls = CLASS_SYSTEM; imm = ii; wr = (f3 != 0);
                   r1 = (f3 >= 1 && f3 <= 3); ok = (f3 != 4); end
      default: ok = 0;
    endcase
    r.ill   = !ok;
    if (!ok) r.cls = CLASS_ILLEGAL;
    r.rs1   = (ok && r1) ? w[19:15] : 5'd0;
    r.rs2   = (ok && r2) ? w[24:20] : 5'd0;
    r.rd_we = ok && wr && (w[11:7] != 5'd0);
    r.imm   = ok ? 32'(imm) : 32'd0;
    return r;
  endfunction

  // Fetch stub and architectural stage model.
  logic [31:0] fq_pc[$];
  logic [31:0] fq_ins[$];
  logic        m_valid;
  logic [31:0] m_pc, m_instr, m_dec, m_bub;

  task automatic apply_fetch();
    if (fq_pc.size() == 0) begin
      i_if_pc = 32'd0; i_if_instruction = NOOP_INSTRUCTION;
    end else begin
      i_if_pc = fq_pc[0]; i_if_instruction = fq_ins[0];
    end
  endtask

  task automatic push(input logic [31:0] pc, input logic [31:0] ins);
    fq_pc.push_back(pc);
    fq_ins.push_back(ins);
  endtask

  always @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      m_valid = 0; m_pc = 0; m_instr = NOOP_INSTRUCTION; m_dec = 0; m_bub = 0;
      fq_pc.delete(); fq_ins.delete();
    end else if (i_redirect) begin
      m_valid = 0; m_pc = 0; m_instr = NOOP_INSTRUCTION;
      fq_pc.delete(); fq_ins.delete();
    end else begin
      if (m_valid && i_ex_ready) m_dec = m_dec + 1;
      if (!m_valid || i_ex_ready) begin
        if (i_if_instruction == NOOP_INSTRUCTION) m_bub = m_bub + 1;
        else if (fq_pc.size() != 0) begin
          void'(fq_pc.pop_front()); void'(fq_ins.pop_front());
        end
        m_valid = (i_if_instruction != NOOP_INSTRUCTION);
        m_pc    = i_if_pc;
        m_instr = i_if_instruction;
      end
    end
  end

  bit started = 0;
  always @(negedge i_clk) begin
    if (started && !i_reset) begin
      ref_t e;
      e = ref_decode(m_instr);
      check("valid", 32'(o_valid), 32'(m_valid));
      check("pc", o_pc, m_pc);
      check("instruction", o_instruction, m_instr);
      check("if_ready", 32'(o_if_ready), 32'((!m_valid || i_ex_ready) || i_redirect));
      check("if_pc_load", 32'(o_if_pc_load), 32'(i_redirect));
      if (i_redirect) check("if_ext_pc", o_if_ext_pc, i_redirect_pc);
      check("decoded_cnt", o_decoded_cnt, m_dec);
      check("bubble_cnt", o_bubble_cnt, m_bub);
      if (m_valid) begin
        check("op_class", 32'(o_op_class), 32'(e.cls));
        check("illegal", 32'(o_illegal), 32'(e.ill));
        check("imm", o_imm, e.imm);
        check("rs1", 32'(o_rs1), 32'(e.rs1));
        check("rs2", 32'(o_rs2), 32'(e.rs2));
        check("rd", 32'(o_rd), 32'(m_instr[11:7]));
        check("rd_we", 32'(o_rd_we), 32'(e.rd_we));
        check("funct3", 32'(o_funct3), 32'(m_instr[14:12]));
        check("funct7b5", 32'(o_funct7b5), 32'(m_instr[30]));
      end
    end
  end

  task automatic tick();
    @(posedge i_clk);
    #1;
    apply_fetch();
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_valid"}, 32'(o_valid), 32'd0);
    check({tag, "_class"}, 32'(o_op_class), 32'(CLASS_OP_IMM));
    check({tag, "_imm"}, o_imm, 32'd0);
    check({tag, "_rd_we"}, 32'(o_rd_we), 32'd0);
    check({tag, "_illegal"}, 32'(o_illegal), 32'd0);
    check({tag, "_pc"}, o_pc, 32'd0);
    check({tag, "_instr"}, o_instruction, 32'h0000_0013);
    check({tag, "_dec_cnt"}, o_decoded_cnt, 32'd0);
    check({tag, "_bub_cnt"}, o_bubble_cnt, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] b0;
    i_reset = 1; i_ex_ready = 1; i_redirect = 0; i_redirect_pc = 0;
    apply_fetch();
    repeat (2) @(posedge i_clk);
    @(negedge i_clk);
    check_reset_values("reset");
    @(posedge i_clk); #1;
    i_reset = 0;
    started = 1;

    // Streaming decode, one per cycle
    push(32'h100, 32'h0050_0093);
    push(32'h104, 32'hFFF0_0113);
    push(32'h108, 32'hFE00_0EE3);
    push(32'h10C, 32'h1234_50B7);
    apply_fetch();
    tick();
    @(negedge i_clk);
    check("addi_valid", 32'(o_valid), 32'd1);
    check("addi_pc", o_pc, 32'h100);
    check("addi_rd", 32'(o_rd), 32'd1);
    check("addi_rd_we", 32'(o_rd_we), 32'd1);
    check("addi_imm", o_imm, 32'd5);
    check("addi_class", 32'(o_op_class), 32'(CLASS_OP_IMM));
    tick();
    @(negedge i_clk);
    check("addi_neg_imm", o_imm, 32'hFFFF_FFFF);
    check("addi_neg_rd", 32'(o_rd), 32'd2);
    tick();
    @(negedge i_clk);
    check("beq_class", 32'(o_op_class), 32'(CLASS_BRANCH));
    check("beq_imm", o_imm, 32'hFFFF_FFFC);
    check("beq_rd_we", 32'(o_rd_we), 32'd0);
    tick();
    @(negedge i_clk);
    check("lui_class", 32'(o_op_class), 32'(CLASS_LUI));
    check("lui_imm", o_imm, 32'h1234_5000);
    check("lui_rs1", 32'(o_rs1), 32'd0);

    // Stall for three cycles, then release
    push(32'h110, 32'h00A0_0193);
    push(32'h114, 32'h00B0_0213);
    apply_fetch();
    tick();
    i_ex_ready = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge i_clk);
      check("stall_pc", o_pc, 32'h110);
      check("stall_if_ready", 32'(o_if_ready), 32'd0);
      tick();
    end
    i_ex_ready = 1;
    tick();
    @(negedge i_clk);
    check("release_pc", o_pc, 32'h114);

    // Redirect while holding a valid instruction and fetch presents a word
    push(32'h118, 32'h00C0_0293);
    apply_fetch();
    i_ex_ready = 0;
    tick();
    i_redirect = 1; i_redirect_pc = 32'h200;
    @(negedge i_clk);
    check("redir_pc_load", 32'(o_if_pc_load), 32'd1);
    check("redir_ext_pc", o_if_ext_pc, 32'h200);
    check("redir_if_ready", 32'(o_if_ready), 32'd1);
    tick();
    i_redirect = 0;
    push(32'h200, 32'h0010_0313);
    apply_fetch();
    i_ex_ready = 1;
    @(negedge i_clk);
    check("redir_squash_valid", 32'(o_valid), 32'd0);
    tick();
    @(negedge i_clk);
    check("redir_first_pc", o_pc, 32'h200);

    // Redirect coincident with execute accepting: redirect wins
    i_redirect = 1; i_redirect_pc = 32'h280;
    tick();
    i_redirect = 0;
    @(negedge i_clk);
    check("redir_ack_valid", 32'(o_valid), 32'd0);

    // Illegal encodings
    push(32'h280, 32'h0000_007F);
    push(32'h284, 32'h4000_1033);
    apply_fetch();
    tick();
    @(negedge i_clk);
    check("ill_opc_flag", 32'(o_illegal), 32'd1);
    check("ill_opc_class", 32'(o_op_class), 32'(CLASS_ILLEGAL));
    check("ill_opc_rd_we", 32'(o_rd_we), 32'd0);
    tick();
    @(negedge i_clk);
    check("ill_f7_flag", 32'(o_illegal), 32'd1);
    check("ill_f7_class", 32'(o_op_class), 32'(CLASS_ILLEGAL));
    check("ill_f7_rd_we", 32'(o_rd_we), 32'd0);

    // Four fetch bubbles
    b0 = m_bub;
    for (int i = 0; i < 4; i++) tick();
    @(negedge i_clk);
    check("bubble_delta", o_bubble_cnt, b0 + 32'd4);
    check("bubble_valid", 32'(o_valid), 32'd0);

    // Asynchronous reset mid-stream with a stalled valid instruction
    push(32'h300, 32'h0050_0093);
    push(32'h304, 32'h0060_0093);
    apply_fetch();
    tick();
    i_ex_ready = 0;
    tick();
    @(negedge i_clk);
    #2;
    i_reset = 1;
    #1;
    check_reset_values("async_reset");
    apply_fetch();
    i_ex_ready = 1;
    @(posedge i_clk); #1;
    i_reset = 0;
    push(32'h400, 32'h0050_0093);
    apply_fetch();
    tick();
    @(negedge i_clk);
    check("post_reset_pc", o_pc, 32'h400);
    tick();
    @(negedge i_clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
